// File: rtl/mag_arbiter_pkg.sv
// Shared definitions for the magnitude arbiter: controller state encoding
// and the elaboration-time ceil(log2) helper used for requester id widths.
package mag_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/abs.sv
// Pipelined CORDIC vectoring magnitude core: z = K * sqrt(x^2 + y^2), K ~ 1.6465.
// STAGE-2 register stages, one CORDIC micro-rotation each; synchronous active-high reset.
module abs #(
    parameter int WIDTH = 18,
    parameter int STAGE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [WIDTH+1:0]   z
);

    localparam int NIT = STAGE - 2;
    localparam int IW  = WIDTH + 2;

    logic signed [IW-1:0] xs  [NIT];
    logic signed [IW-1:0] ys  [NIT];
    logic signed [IW-1:0] xin [NIT];
    logic signed [IW-1:0] yin [NIT];
    logic signed [IW-1:0] xnx [NIT];
    logic signed [IW-1:0] ynx [NIT];

    // Left-half-plane inputs are rotated by 180 degrees so every vector starts with x >= 0.
    always_comb begin
        xin[0] = {{2{x[WIDTH-1]}}, x};
        yin[0] = {{2{y[WIDTH-1]}}, y};
        if (x[WIDTH-1]) begin
            xin[0] = -xin[0];
            yin[0] = -yin[0];
        end
        for (int i = 1; i < NIT; i++) begin
            xin[i] = xs[i-1];
            yin[i] = ys[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < NIT; i++) begin
            if (yin[i][IW-1]) begin
                xnx[i] = xin[i] - (yin[i] >>> i);
                ynx[i] = yin[i] + (xin[i] >>> i);
            end else begin
                xnx[i] = xin[i] + (yin[i] >>> i);
                ynx[i] = yin[i] - (xin[i] >>> i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NIT; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIT; i++) begin
                xs[i] <= xnx[i];
                ys[i] <= ynx[i];
            end
        end
    end

    assign z = xs[NIT-1];

endmodule

// File: rtl/mag_arbiter.sv
// Round-robin arbiter feeding NREQ I/Q requesters into one shared magnitude pipeline,
// with a {valid, id} tag pipeline that routes each result back to its owner.
module mag_arbiter
    import mag_arbiter_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int STAGE = 8,
    parameter int NREQ  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_x,
    input  logic [NREQ*WIDTH-1:0]    req_y,
    output logic [NREQ-1:0]          req_ready,
    output logic                     res_valid,
    output logic [clog2(NREQ)-1:0]   res_id,
    output logic [WIDTH+1:0]         res_z,
    output logic                     busy,
    output logic [15:0]              issue_cnt
);

    localparam int LAT = STAGE - 1;
    localparam int IDW = clog2(NREQ);

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic             xfer;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic [WIDTH+1:0] core_z;

    // Tag stages 0..LAT-2 track the core; res_valid/res_id form the final stage.
    logic [LAT-2:0]   tag_valid;
    logic [IDW-1:0]   tag_id [LAT-1];

    // NOTE: combinational logic uses blocking '=' and assigns every output a default
    // before the loop, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    assign xfer      = (state == RUN) && en && grant_any;
    assign req_ready = xfer ? (NREQ'(1) << grant_id) : '0;
    assign sel_x     = req_x[int'(grant_id)*WIDTH +: WIDTH];
    assign sel_y     = req_y[int'(grant_id)*WIDTH +: WIDTH];
    assign busy      = (state != IDLE) || (|tag_valid) || res_valid;

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            issue_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (!en) state <= DRAIN;
                DRAIN:   if (en) state <= RUN;
                         else if (!(|tag_valid)) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (xfer) begin
                last_grant <= grant_id;
                if (issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_z     <= '0;
        end else begin
            tag_valid[0] <= xfer;
            for (int i = 1; i < LAT - 1; i++) tag_valid[i] <= tag_valid[i-1];
            res_valid <= tag_valid[LAT-2];
            if (tag_valid[LAT-2]) begin
                res_id <= tag_id[LAT-2];
                res_z  <= core_z;
            end
        end
    end

    // NOTE: tag ids are pure data qualified by tag_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_id[0] <= grant_id;
        for (int i = 1; i < LAT - 1; i++) tag_id[i] <= tag_id[i-1];
    end

    abs #(
        .WIDTH (WIDTH),
        .STAGE (STAGE)
    ) u_abs (
        .clk (clk),
        .rst (~rst),
        .x   (sel_x),
        .y   (sel_y),
        .z   (core_z)
    );

endmodule

// File: tb/tb_mag_arbiter.sv
// Self-checking bench for mag_arbiter: vector table, directed multi-cycle sequences,
// and randomized traffic checked against a queue-based behavioural model.
module tb_mag_arbiter;

    localparam int WIDTH = 18;
    localparam int STAGE = 8;
    localparam int NREQ  = 4;
    localparam int LAT   = STAGE - 1;
    localparam int IDW   = $clog2(NREQ);
    localparam real KGAIN = 1.6468;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   en = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*WIDTH-1:0]  req_x = '0;
    logic [NREQ*WIDTH-1:0]  req_y = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   res_valid;
    logic [IDW-1:0]         res_id;
    logic [WIDTH+1:0]       res_z;
    logic                   busy;
    logic [15:0]            issue_cnt;

    mag_arbiter #(
        .WIDTH (WIDTH),
        .STAGE (STAGE),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_z     (res_z),
        .busy      (busy),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    int     n_pass = 0;
    int     n_total = 0;
    longint cyc = 0;
    bit     mon_en = 1'b1;
    int     gq[$];
    int     rq[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit near(input real act, input real exp);
        real tol;
        tol = 16.0 + 0.002 * exp;
        return (act - exp <= tol) && (exp - act <= tol);
    endfunction

    function automatic real mag(input int x, input int y);
        real rx, ry;
        rx = x;
        ry = y;
        return KGAIN * $sqrt(rx * rx + ry * ry);
    endfunction

    function automatic int comp(input logic [NREQ*WIDTH-1:0] v, input int r);
        logic signed [WIDTH-1:0] s;
        s = v[r*WIDTH +: WIDTH];
        return int'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int x, input int y);
        req_x[r*WIDTH +: WIDTH] = x[WIDTH-1:0];
        req_y[r*WIDTH +: WIDTH] = y[WIDTH-1:0];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Grant / result collector used by the directed sequences.
    always @(negedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREQ; r++) if (req_ready[r]) gq.push_back(r);
            if (res_valid) rq.push_back(int'(res_id));
        end
    end

    // Behavioural reference: controller rules, round-robin search, in-flight queue.
    typedef struct {
        int     id;
        int     x;
        int     y;
        longint due;
    } flight_t;

    flight_t m_q[$];
    int      m_st = 0;
    int      m_ptr = NREQ - 1;
    int      m_cnt = 0;
    int      m_last_id = 0;

    task automatic model_step();
        int g;
        logic [NREQ-1:0] exp_ready;
        bit delivering;
        bit exp_busy;
        flight_t f;
        if (!rst) begin
            m_q.delete();
            m_st = 0;
            m_ptr = NREQ - 1;
            m_cnt = 0;
            m_last_id = 0;
            check("rst_ready", req_ready == '0, req_ready, 0);
            check("rst_res_valid", res_valid == 1'b0, res_valid, 0);
            check("rst_res_id", res_id == '0, res_id, 0);
            check("rst_res_z", res_z == '0, res_z, 0);
            check("rst_busy", busy == 1'b0, busy, 0);
            check("rst_issue_cnt", issue_cnt == 16'd0, issue_cnt, 0);
            return;
        end
        g = -1;
        if (m_st == 1 && en) begin
            for (int k = 1; k <= NREQ; k++) begin
                int r;
                r = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[r]) g = r;
            end
        end
        exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
        check("grant", req_ready == exp_ready, req_ready, exp_ready);
        exp_busy = (m_st != 0) || (m_q.size() > 0);
        check("busy", busy == exp_busy, busy, exp_busy);
        check("issue_cnt", int'(issue_cnt) == m_cnt, issue_cnt, m_cnt);
        delivering = (m_q.size() > 0) && (m_q[0].due == cyc);
        check("res_valid", res_valid == delivering, res_valid, delivering);
        if (delivering) begin
            check("res_id", int'(res_id) == m_q[0].id, res_id, m_q[0].id);
            check("res_z", near(real'(res_z), mag(m_q[0].x, m_q[0].y)), res_z,
                  longint'(mag(m_q[0].x, m_q[0].y)));
            m_last_id = m_q[0].id;
            void'(m_q.pop_front());
        end else begin
            check("res_id_hold", int'(res_id) == m_last_id, res_id, m_last_id);
        end
        if (g >= 0) begin
            f.id = g;
            f.x = comp(req_x, g);
            f.y = comp(req_y, g);
            f.due = cyc + LAT;
            m_q.push_back(f);
            m_ptr = g;
            if (m_cnt < 65535) m_cnt++;
        end
        case (m_st)
            0: if (en) m_st = 1;
            1: if (!en) m_st = 2;
            default: if (en) m_st = 1; else if (m_q.size() == 0) m_st = 0;
        endcase
    endtask

    always @(negedge clk) if (mon_en) model_step();

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int id;
        int x;
        int y;
        int exp_z;
    } vec_t;

    vec_t vecs [10];
    bit   bh [15];
    bit   vh [15];

    initial begin
        int last;
        int bad;
        bit got;

        vecs[0] = '{0,    1000,      0,   1647};
        vecs[1] = '{1,       0,   1000,   1647};
        vecs[2] = '{2,   -1000,      0,   1647};
        vecs[3] = '{3,    3000,   4000,   8234};
        vecs[4] = '{0,   -3000,  -4000,   8234};
        vecs[5] = '{1,       0,      0,      0};
        vecs[6] = '{2,  131071,      0, 215848};
        vecs[7] = '{3, -131072, -131072, 305257};
        vecs[8] = '{0,       1,      1,      2};
        vecs[9] = '{1,   -5000,  12000,  21408};

        // Single-sample vectors: grant, latency, owner id, magnitude.
        do_reset();
        en = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            set_req(vecs[i].id, vecs[i].x, vecs[i].y);
            req_valid = NREQ'(1 << vecs[i].id);
            @(negedge clk);
            check("tbl_grant", req_ready == NREQ'(1 << vecs[i].id), req_ready, 1 << vecs[i].id);
            tick();
            req_valid = '0;
            got = 1'b0;
            for (int k = 1; k <= 20 && !got; k++) begin
                @(negedge clk);
                if (res_valid) begin
                    got = 1'b1;
                    check("tbl_latency", k == LAT, k, LAT);
                    check("tbl_id", int'(res_id) == vecs[i].id, res_id, vecs[i].id);
                    check("tbl_z", near(real'(res_z), real'(vecs[i].exp_z)), res_z, vecs[i].exp_z);
                end
                tick();
            end
            check("tbl_result_seen", got, got, 1);
        end

        // All requesters valid for 12 cycles.
        do_reset();
        en = 1'b1;
        tick();
        for (int r = 0; r < NREQ; r++) set_req(r, 100 * (r + 1), -50 * r);
        gq.delete();
        rq.delete();
        req_valid = '1;
        repeat (12) tick();
        req_valid = '0;
        repeat (12) tick();
        check("rr_grant_count", gq.size() == 12, gq.size(), 12);
        check("rr_result_count", rq.size() == 12, rq.size(), 12);
        for (int i = 0; i < 12 && i < gq.size(); i++) check("rr_grant_order", gq[i] == i % 4, gq[i], i % 4);
        for (int i = 0; i < 12 && i < rq.size(); i++) check("rr_result_order", rq[i] == i % 4, rq[i], i % 4);
        check("rr_issue_cnt", issue_cnt == 16'd12, issue_cnt, 12);

        // Sparse request pattern 1010.
        do_reset();
        en = 1'b1;
        tick();
        gq.delete();
        req_valid = 4'b1010;
        repeat (8) tick();
        req_valid = '0;
        repeat (10) tick();
        check("sparse_grant_count", gq.size() == 8, gq.size(), 8);
        bad = 0;
        for (int i = 0; i < gq.size(); i++) begin
            check("sparse_grant_order", gq[i] == ((i % 2) ? 3 : 1), gq[i], (i % 2) ? 3 : 1);
            if (gq[i] == 0 || gq[i] == 2) bad++;
        end
        check("sparse_never_0_or_2", bad == 0, bad, 0);

        // en dropped after 5 back-to-back issues.
        do_reset();
        en = 1'b1;
        tick();
        gq.delete();
        rq.delete();
        req_valid = '1;
        repeat (5) tick();
        en = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            bh[k] = busy;
            vh[k] = res_valid;
            tick();
        end
        req_valid = '0;
        last = -1;
        for (int k = 0; k < 15; k++) if (vh[k]) last = k;
        check("drain_grants", gq.size() == 5, gq.size(), 5);
        check("drain_results", rq.size() == 5, rq.size(), 5);
        check("drain_last_result_cycle", last == LAT - 1, last, LAT - 1);
        if (last >= 0 && last < 14) begin
            check("drain_busy_at_last", bh[last] == 1'b1, bh[last], 1);
            check("drain_busy_after", bh[last+1] == 1'b0, bh[last+1], 0);
        end

        // Reset three cycles after an issue, outputs still holding earlier results.
        en = 1'b1;
        tick();
        set_req(2, 7000, 7000);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_ready", req_ready == '0, req_ready, 0);
        check("mid_rst_res_valid", res_valid == 1'b0, res_valid, 0);
        check("mid_rst_res_id", res_id == '0, res_id, 0);
        check("mid_rst_res_z", res_z == '0, res_z, 0);
        check("mid_rst_busy", busy == 1'b0, busy, 0);
        check("mid_rst_issue_cnt", issue_cnt == 16'd0, issue_cnt, 0);
        en = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        rq.delete();
        repeat (15) tick();
        check("mid_rst_no_results", rq.size() == 0, rq.size(), 0);
        check("mid_rst_cnt_after", issue_cnt == 16'd0, issue_cnt, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 9) != 0);
            req_valid = NREQ'($urandom);
            for (int r = 0; r < NREQ; r++) set_req(r, int'($urandom), int'($urandom));
            tick();
        end
        en = 1'b0;
        req_valid = '0;
        repeat (20) tick();
        @(negedge clk);
        check("rand_idle_after_drain", busy == 1'b0, busy, 0);
        tick();

        // Saturation of issue_cnt.
        do_reset();
        mon_en = 1'b0;
        en = 1'b1;
        tick();
        req_valid = '1;
        repeat (65535) tick();
        req_valid = '0;
        @(negedge clk);
        check("sat_reached", issue_cnt == 16'hFFFF, issue_cnt, 65535);
        tick();
        gq.delete();
        req_valid = '1;
        repeat (3) tick();
        req_valid = '0;
        @(negedge clk);
        check("sat_extra_grants", gq.size() == 3, gq.size(), 3);
        check("sat_held", issue_cnt == 16'hFFFF, issue_cnt, 65535);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
